ethernet_frame_transmitter: RTL and testbench
=============================================

ETHERNET_FRAME_TRANSMITTER -- requirements
Module: ethernet_frame_transmitter

Interface
REQ-001 SHALL have parameter MINIMUM_PAYLOAD_BYTES, default 60, minimum bytes before FCS (payload plus padding), range 0..1500.
REQ-002 SHALL have parameter INTER_PACKET_GAP_BYTES, default 12, idle cycles after each frame, range 1..255.
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits starting a new frame.
REQ-006 SHALL have port transmit_data  input  9  bits [7:0] payload byte, bit [8] last-byte flag.
REQ-007 SHALL have port transmit_data_enable  input  1  transmit_data valid.
REQ-008 SHALL have port transmit_data_ready  output  1  block accepts transmit_data this cycle.
REQ-009 SHALL have port transmit_byte  output  8  framed byte to the RGMII nibble/DDR stage.
REQ-010 SHALL have port transmit_byte_valid  output  1  transmit_byte valid; downstream consumes one byte every cycle.
REQ-011 SHALL have port underrun_error  output  1  one-cycle pulse on frame abort.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, GAP; all outputs registered.
REQ-014 IDLE -> PREAMBLE when enable=1 and transmit_data_enable=1; the waiting byte is not consumed.
REQ-015 PREAMBLE SHALL emit 0x55 for exactly 7 cycles, then SFD emits 0xD5 for 1 cycle; first 0x55 appears the cycle after the IDLE start condition.
REQ-016 transmit_data_ready SHALL be 1 only in PAYLOAD; a byte is accepted when transmit_data_ready=1 and transmit_data_enable=1, and appears on transmit_byte the next cycle.
REQ-017 PAYLOAD with transmit_data_enable=0 (underrun) SHALL drop transmit_byte_valid that cycle, pulse underrun_error, skip PAD and FCS, and enter GAP.
REQ-018 An 11-bit byte counter SHALL count payload plus pad bytes, saturating at 2047, cleared on entering PREAMBLE.
REQ-019 On accepting a byte with bit [8]=1: counter < MINIMUM_PAYLOAD_BYTES -> PAD, otherwise -> FCS.
REQ-020 PAD SHALL emit 0x00 until the counter equals MINIMUM_PAYLOAD_BYTES, then go to FCS.
REQ-021 CRC-32 SHALL use reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated over payload and pad bytes only (not preamble/SFD).
REQ-022 FCS SHALL emit the bitwise complement of the CRC register for 4 cycles, least-significant byte first, then go to GAP.
REQ-023 GAP SHALL hold transmit_byte_valid=0 for exactly INTER_PACKET_GAP_BYTES cycles, then go to IDLE.
REQ-024 enable deasserted mid-frame SHALL NOT affect the frame in progress; it only blocks the next IDLE -> PREAMBLE transition.
REQ-025 transmit_byte SHALL be 0x00 whenever transmit_byte_valid=0.

Reset
REQ-026 reset=1 SHALL force IDLE on the next clock edge from any state, aborting any frame without underrun_error.
REQ-027 Reset values SHALL be: transmit_data_ready=0, transmit_byte=0x00, transmit_byte_valid=0, underrun_error=0, busy=0, counter=0, CRC=0xFFFFFFFF.

Configuration
REQ-028 Macro ETHERNET_TX_FCS_INSERT_EN defined: FCS state and CRC logic are built, behaving per REQ-021/022.
REQ-029 Macro ETHERNET_TX_FCS_INSERT_EN undefined: no CRC logic; PAYLOAD/PAD go directly to GAP (upstream supplies the FCS), with padding still applied per REQ-019/020.

Verification
REQ-030 Macro on, defaults, one byte 0x01 with last=1 -> 7x0x55, 0xD5, 0x01, 59x0x00, 4 FCS bytes matching a reference CRC-32 model, then 12 cycles with valid=0, busy=0 afterwards.
REQ-031 Macro on, MINIMUM_PAYLOAD_BYTES=0, payload ASCII "123456789" -> no padding, FCS bytes 0x26 0x39 0xF4 0xCB.
REQ-032 Defaults, two back-to-back 64-byte frames with transmit_data_enable held high -> exactly 12 valid=0 cycles between the last FCS byte of frame 1 and the first 0x55 of frame 2; no pad bytes.
REQ-033 transmit_data_enable drops after the 10th payload byte -> underrun_error high for 1 cycle, no pad or FCS bytes, 12-cycle GAP, then IDLE.
REQ-034 reset asserted for 1 cycle during PAYLOAD -> next cycle all outputs at reset values; a new frame then starts cleanly with 7x0x55.
REQ-035 Macro off, defaults, 70-byte frame -> preamble, SFD, 70 payload bytes, then GAP immediately with no trailing FCS bytes.

Source files
------------

// File: rtl/ethernet_frame_transmitter.sv
// rtl/ethernet_frame_transmitter.sv - Ethernet framer (preamble, SFD, payload, pad, optional FCS via ETHERNET_TX_FCS_INSERT_EN, gap)
module ethernet_frame_transmitter #(
  parameter int MINIMUM_PAYLOAD_BYTES  = 60,
  parameter int INTER_PACKET_GAP_BYTES = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] transmit_data,
  input  logic       transmit_data_enable,
  output logic       transmit_data_ready,
  output logic [7:0] transmit_byte,
  output logic       transmit_byte_valid,
  output logic       underrun_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    GAP
  } state_t;

  localparam logic [10:0] MIN_COUNT = 11'(MINIMUM_PAYLOAD_BYTES);
  localparam logic [7:0]  GAP_LAST  = 8'(INTER_PACKET_GAP_BYTES - 1);

`ifdef ETHERNET_TX_FCS_INSERT_EN
  localparam state_t AFTER_DATA = FCS;
`else
  localparam state_t AFTER_DATA = GAP;
`endif

  // The state register leads the output by one cycle: each state decides the
  // byte presented after the coming edge, so SFD and payload run without bubbles.
  state_t      state;
  logic [2:0]  preamble_count;
  logic [7:0]  gap_count;
  logic [10:0] byte_count;
  logic [10:0] count_next;

  // Payload-plus-pad counter saturates rather than wrapping.
  assign count_next = (byte_count == 11'd2047) ? byte_count : byte_count + 11'd1;

`ifdef ETHERNET_TX_FCS_INSERT_EN
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [1:0]  fcs_index;

  // Reflected CRC-32 (0xEDB88320), one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs_word = ~crc;
`endif

  // Frame sequencer: all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      preamble_count      <= '0;
      gap_count           <= '0;
      byte_count          <= '0;
      transmit_data_ready <= 1'b0;
      transmit_byte       <= 8'h00;
      transmit_byte_valid <= 1'b0;
      underrun_error      <= 1'b0;
      busy                <= 1'b0;
`ifdef ETHERNET_TX_FCS_INSERT_EN
      crc                 <= 32'hFFFFFFFF;
      fcs_index           <= '0;
`endif
    end else begin
      underrun_error      <= 1'b0;
      transmit_byte_valid <= 1'b0;
      transmit_byte       <= 8'h00;
      if (state != GAP) gap_count <= '0;
`ifdef ETHERNET_TX_FCS_INSERT_EN
      if (state != FCS) fcs_index <= '0;
`endif
      case (state)
        IDLE: begin
          if (enable && transmit_data_enable) begin
            state               <= PREAMBLE;
            busy                <= 1'b1;
            transmit_byte       <= 8'h55;
            transmit_byte_valid <= 1'b1;
            preamble_count      <= 3'd1;
            byte_count          <= '0;
`ifdef ETHERNET_TX_FCS_INSERT_EN
            crc                 <= 32'hFFFFFFFF;
`endif
          end
        end
        PREAMBLE: begin
          transmit_byte       <= 8'h55;
          transmit_byte_valid <= 1'b1;
          preamble_count      <= preamble_count + 3'd1;
          if (preamble_count == 3'd6) state <= SFD;
        end
        SFD: begin
          transmit_byte       <= 8'hD5;
          transmit_byte_valid <= 1'b1;
          transmit_data_ready <= 1'b1;
          state               <= PAYLOAD;
        end
        PAYLOAD: begin
          if (transmit_data_enable) begin
            transmit_byte       <= transmit_data[7:0];
            transmit_byte_valid <= 1'b1;
            byte_count          <= count_next;
`ifdef ETHERNET_TX_FCS_INSERT_EN
            crc                 <= crc_byte(crc, transmit_data[7:0]);
`endif
            if (transmit_data[8]) begin
              transmit_data_ready <= 1'b0;
              if (count_next < MIN_COUNT) state <= PAD;
              else                        state <= AFTER_DATA;
            end
          end else begin
            // Underrun: abandon the frame without pad or FCS.
            transmit_data_ready <= 1'b0;
            underrun_error      <= 1'b1;
            state               <= GAP;
          end
        end
        PAD: begin
          transmit_byte_valid <= 1'b1;
          byte_count          <= count_next;
`ifdef ETHERNET_TX_FCS_INSERT_EN
          crc                 <= crc_byte(crc, 8'h00);
`endif
          if (count_next >= MIN_COUNT) state <= AFTER_DATA;
        end
`ifdef ETHERNET_TX_FCS_INSERT_EN
        FCS: begin
          transmit_byte       <= fcs_word[{fcs_index, 3'b000} +: 8];
          transmit_byte_valid <= 1'b1;
          fcs_index           <= fcs_index + 2'd1;
          if (fcs_index == 2'd3) state <= GAP;
        end
`endif
        GAP: begin
          if (gap_count == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_count <= gap_count + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_frame_transmitter.sv
// tb/tb_ethernet_frame_transmitter.sv - self-checking bench for ethernet_frame_transmitter
module tb_ethernet_frame_transmitter;

  localparam int FCS_LEN = `ifdef ETHERNET_TX_FCS_INSERT_EN 4 `else 0 `endif;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       enable0, enable1;
  logic [8:0] data0, data1;
  logic       tde0, tde1;
  logic       ready0, ready1;
  logic [7:0] byte0, byte1;
  logic       valid0, valid1;
  logic       under0, under1;
  logic       busy0, busy1;

  ethernet_frame_transmitter dut0 (
    .clock(clock), .reset(reset), .enable(enable0),
    .transmit_data(data0), .transmit_data_enable(tde0),
    .transmit_data_ready(ready0), .transmit_byte(byte0),
    .transmit_byte_valid(valid0), .underrun_error(under0), .busy(busy0)
  );

  ethernet_frame_transmitter #(.MINIMUM_PAYLOAD_BYTES(0), .INTER_PACKET_GAP_BYTES(3)) dut1 (
    .clock(clock), .reset(reset), .enable(enable1),
    .transmit_data(data1), .transmit_data_enable(tde1),
    .transmit_data_ready(ready1), .transmit_byte(byte1),
    .transmit_byte_valid(valid1), .underrun_error(under1), .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] cap0[$], cap1[$];
  int         t0[$], t1[$];
  int         zero_bad = 0;
  int         under_pulses0 = 0, under_cycles0 = 0, under_cyc0 = 0;
  int         under_pulses1 = 0;
  logic       under_prev0 = 1'b0, busy_prev0 = 1'b0, busy_prev1 = 1'b0;
  int         fall0 = 0, fall1 = 0;

  // Output monitor for dut0
  always @(negedge clock) begin
    if (valid0) begin
      cap0.push_back(byte0);
      t0.push_back(cyc);
    end else if (byte0 != 8'h00) begin
      zero_bad <= zero_bad + 1;
    end
    if (under0) begin
      under_cycles0 <= under_cycles0 + 1;
      if (!under_prev0) begin
        under_pulses0 <= under_pulses0 + 1;
        under_cyc0    <= cyc;
      end
    end
    under_prev0 <= under0;
    if (busy_prev0 && !busy0) fall0 <= cyc;
    busy_prev0 <= busy0;
  end

  // Output monitor for dut1
  always @(negedge clock) begin
    if (valid1) begin
      cap1.push_back(byte1);
      t1.push_back(cyc);
    end else if (byte1 != 8'h00) begin
      zero_bad <= zero_bad + 1;
    end
    if (under1) under_pulses1 <= under_pulses1 + 1;
    if (busy_prev1 && !busy1) fall1 <= cyc;
    busy_prev1 <= busy1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    end
    return ~c;
  endfunction

  function automatic int count_diff(input logic [7:0] a[$], input logic [7:0] e[$]);
    int n = 0;
    int m = (a.size() > e.size()) ? a.size() : e.size();
    for (int i = 0; i < m; i++) begin
      if (i >= a.size() || i >= e.size()) n++;
      else if (a[i] != e[i]) n++;
    end
    return n;
  endfunction

  task automatic set_in(input int which, input logic [8:0] d, input logic t);
    if (which == 0) begin data0 = d; tde0 = t; end
    else            begin data1 = d; tde1 = t; end
  endtask

  // Presents words back to back, advancing after each accepted one; tde drops after the last.
  task automatic stream(input int which, input logic [8:0] w[$], input bit drop_en);
    int idx = 0;
    int budget = 0;
    bit took = 1'b0;
    set_in(which, w[0], 1'b1);
    while (idx < w.size() && budget < 5000) begin
      @(negedge clock);
      budget++;
      if (drop_en && which == 0 && busy0) enable0 = 1'b0;
      if (took) begin
        idx++;
        if (idx < w.size()) set_in(which, w[idx], 1'b1);
        else                set_in(which, 9'h000, 1'b0);
      end
      took = (which == 0) ? ready0 : ready1;
    end
    check("stream_done", idx, w.size());
    set_in(which, 9'h000, 1'b0);
  endtask

  task automatic wait_idle(input int which);
    int  budget = 0;
    bit  idle = 1'b0;
    while (!idle && budget < 3000) begin
      @(negedge clock);
      budget++;
      idle = (which == 0) ? !busy0 : !busy1;
    end
    check("idle_reached", idle, 1);
    repeat (2) @(negedge clock);
  endtask

  typedef struct {
    int         len;
    logic [7:0] seed;
    bit         drop_en;
    int         exp_pad;
  } frame_vec_t;

  frame_vec_t vecs[5];

  initial begin
    logic [8:0]  words[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  crc_in[$];
    logic [7:0]  b;
    logic [31:0] c;
    int          base, base_c, k, budget;

    vecs[0] = '{1,  8'h01, 1'b0, 59};
    vecs[1] = '{59, 8'h10, 1'b0, 1};
    vecs[2] = '{60, 8'hA0, 1'b1, 0};
    vecs[3] = '{61, 8'h33, 1'b0, 0};
    vecs[4] = '{70, 8'h5A, 1'b0, 0};

    reset = 1'b1; enable0 = 1'b1; enable1 = 1'b1;
    data0 = '0; data1 = '0; tde0 = 1'b0; tde1 = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ready", ready0, 0);
    check("reset_byte", byte0, 0);
    check("reset_valid", valid0, 0);
    check("reset_underrun", under0, 0);
    check("reset_busy", busy0, 0);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven frames on the default-parameter instance
    foreach (vecs[v]) begin
      words.delete(); exp_q.delete(); crc_in.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int j = 0; j < vecs[v].len; j++) begin
        b = vecs[v].seed + 8'(j * 13);
        words.push_back({(j == vecs[v].len - 1), b});
        exp_q.push_back(b);
        crc_in.push_back(b);
      end
      for (int p = 0; p < vecs[v].exp_pad; p++) begin
        exp_q.push_back(8'h00);
        crc_in.push_back(8'h00);
      end
`ifdef ETHERNET_TX_FCS_INSERT_EN
      c = ref_crc(crc_in);
      exp_q.push_back(c[7:0]);  exp_q.push_back(c[15:8]);
      exp_q.push_back(c[23:16]); exp_q.push_back(c[31:24]);
`endif
      cap0.delete(); t0.delete();
      stream(0, words, vecs[v].drop_en);
      wait_idle(0);
      enable0 = 1'b1;
      check($sformatf("vec%0d_len", v), cap0.size(), 8 + vecs[v].len + vecs[v].exp_pad + FCS_LEN);
      check($sformatf("vec%0d_bytes_wrong", v), count_diff(cap0, exp_q), 0);
      check($sformatf("vec%0d_contiguous", v), (t0.size() > 0) ? t0[$] - t0[0] : -1, cap0.size() - 1);
      check($sformatf("vec%0d_gap", v), (t0.size() > 0) ? fall0 - t0[$] : -1, 12);
    end
    check("no_stray_underrun", under_pulses0, 0);

    // enable low blocks a new frame
    cap0.delete(); t0.delete();
    enable0 = 1'b0; data0 = 9'h0AA; tde0 = 1'b1;
    repeat (5) @(negedge clock);
    check("enable_block_busy", busy0, 0);
    check("enable_block_out", cap0.size(), 0);
    tde0 = 1'b0; enable0 = 1'b1;
    @(negedge clock);

    // Underrun after the 10th payload byte
    words.delete();
    for (int j = 0; j < 10; j++) words.push_back({1'b0, 8'(8'h40 + j)});
    base = under_pulses0; base_c = under_cycles0;
    cap0.delete(); t0.delete();
    stream(0, words, 1'b0);
    wait_idle(0);
    check("underrun_len", cap0.size(), 18);
    check("underrun_pulses", under_pulses0 - base, 1);
    check("underrun_width", under_cycles0 - base_c, 1);
    check("underrun_gap", fall0 - under_cyc0, 12);

    // Two back-to-back 64-byte frames
    words.delete();
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 64; j++) words.push_back({(j == 63), 8'(j + f * 64)});
    cap0.delete(); t0.delete();
    stream(0, words, 1'b0);
    wait_idle(0);
    check("b2b_len", cap0.size(), 2 * (8 + 64 + FCS_LEN));
    k = 8 + 64 + FCS_LEN;
    check("b2b_second_start", (cap0.size() > k) ? cap0[k] : 0, 8'h55);
    check("b2b_gap_cycles", (t0.size() > k) ? t0[k] - t0[k-1] - 1 : -1, 12);

    // Reset in the middle of PAYLOAD
    base = under_pulses0;
    data0 = 9'h03C; tde0 = 1'b1;
    budget = 0;
    while (!ready0 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    check("reset_mid_reached_payload", ready0, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1; tde0 = 1'b0;
    @(negedge clock);
    check("reset_mid_outputs", {ready0, valid0, under0, busy0, byte0}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("reset_mid_no_underrun", under_pulses0 - base, 0);
    cap0.delete(); t0.delete();
    words.delete();
    words.push_back(9'h1C3);
    stream(0, words, 1'b0);
    wait_idle(0);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'hC3);
    while (cap0.size() > 9) void'(cap0.pop_back());
    check("reset_restart_head_wrong", count_diff(cap0, exp_q), 0);
    check("reset_restart_len", t0.size(), 8 + 1 + 59 + FCS_LEN);

    // "123456789" on the zero-minimum instance, gap 3
    words.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int j = 0; j < 9; j++) begin
      words.push_back({(j == 8), 8'(8'h31 + j)});
      exp_q.push_back(8'(8'h31 + j));
    end
`ifdef ETHERNET_TX_FCS_INSERT_EN
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
`endif
    cap1.delete(); t1.delete();
    stream(1, words, 1'b0);
    wait_idle(1);
    check("check_string_len", cap1.size(), 17 + FCS_LEN);
    check("check_string_bytes_wrong", count_diff(cap1, exp_q), 0);
    check("check_string_gap", (t1.size() > 0) ? fall1 - t1[$] : -1, 3);
    check("check_string_underrun", under_pulses1, 0);

    check("idle_byte_nonzero", zero_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
